wtime_calc: RTL and testbench

WTIME_CALC -- requirements
Module: wtime_calc

---
 rtl/wtime_pkg.sv | 25 ++
 rtl/wtime_calc_seq_divider.sv | 66 ++++++
 rtl/wtime_calc.sv | 93 +++++++++
 tb/tb_wtime_calc.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/wtime_pkg.sv
// Shared types and helpers for the wait-time calculator: FSM states,
// numerator width derivation and result saturation.
package wtime_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_DONE
  } state_t;

  // Bits needed to hold the largest numerator svc*(Pmax+Tmax-1).
  function automatic int nw_calc(input int pw, input int tw, input int svc);
    int max_num;
    max_num = svc * (((1 << pw) - 1) + ((1 << tw) - 1) - 1);
    return (max_num < 2) ? 1 : $clog2(max_num + 1);
  endfunction

  function automatic logic [31:0] sat_q(input logic [31:0] q, input int ww);
    logic [31:0] lim;
    lim = (32'd1 << ww) - 32'd1;
    return (q > lim) ? lim : q;
  endfunction

endpackage

// File: rtl/wtime_calc_seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle for NW cycles.
// The first bit is produced on the start edge; o_quo is valid while o_done=1.
module seq_divider #(
  parameter int NW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [NW-1:0] i_num,
  input  logic [NW-1:0] i_den,
  output logic          o_done,
  output logic [NW-1:0] o_quo
);

  localparam int CW = $clog2(NW + 1);

  logic [NW-1:0] r_rem, r_quo, r_den;
  logic [CW-1:0] r_cnt;
  logic          r_run;

  logic [NW-1:0] w_rem_src, w_quo_src, w_den;
  logic [NW:0]   w_shift, w_diff;
  logic [NW-1:0] w_rem_nxt, w_quo_nxt;
  logic          w_step;

  always_comb begin
    w_rem_src = i_start ? '0 : r_rem;
    w_quo_src = i_start ? i_num : r_quo;
    w_den     = i_start ? i_den : r_den;
    w_shift   = {w_rem_src, w_quo_src[NW-1]};
    w_diff    = w_shift - {1'b0, w_den};
    // Negative trial difference: restore the shifted remainder, quotient bit 0.
    w_rem_nxt = w_diff[NW] ? w_shift[NW-1:0] : w_diff[NW-1:0];
    w_quo_nxt = (w_quo_src << 1) | NW'(!w_diff[NW]);
    w_step    = i_start | (r_run & (r_cnt != '0));
  end

  assign o_done = i_start ? (NW == 1) : (r_run && (r_cnt == CW'(1)));
  assign o_quo  = w_quo_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= CW'(NW - 1);
    end else if (r_run) begin
      if (r_cnt <= CW'(1)) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_step) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_den <= w_den;
    end
  end

endmodule

// File: rtl/wtime_calc.sv
// Wait-time calculator: wtime = floor(SVC*(P+T-1)/T), zero when P or T is 0,
// saturated to WW bits, with a fixed NW+2 cycle latency from start acceptance.
module wtime_calc
  import wtime_pkg::*;
#(
  parameter int PW  = 3,
  parameter int TW  = 2,
  parameter int SVC = 3,
  parameter int WW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] pcount,
  input  logic [TW-1:0] tcount,
  output logic          busy,
  output logic          done,
  output logic [WW-1:0] wtime
);

  localparam int NW = nw_calc(PW, TW, SVC);

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_p;
  logic [TW-1:0] r_t;
  logic [NW-1:0] r_num, r_den;
  logic          r_zero;
  logic          r_div_go;
  logic [WW-1:0] r_wtime;

  logic [NW-1:0] w_num;
  logic          w_zero;
  logic          w_div_done;
  logic [NW-1:0] w_quo;

  always_comb begin
    w_num  = NW'(SVC) * (NW'(r_p) + NW'(r_t) - NW'(1));
    w_zero = (r_p == '0) || (r_t == '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_DIV;
      S_DIV:   if (w_div_done) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_div_go <= 1'b0;
      r_wtime  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_div_go <= (r_state == S_LOAD);
      if (r_state == S_DIV && w_div_done)
        r_wtime <= r_zero ? '0 : WW'(sat_q(32'(w_quo), WW));
    end
  end

  // Operands are frozen at acceptance; a zero case feeds divisor 1 so the
  // divider still runs its full length and the latency stays constant.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_p <= pcount;
      r_t <= tcount;
    end
    if (r_state == S_LOAD) begin
      r_zero <= w_zero;
      r_num  <= w_zero ? '0 : w_num;
      r_den  <= w_zero ? NW'(1) : NW'(r_t);
    end
  end

  seq_divider #(.NW(NW)) u_div (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_div_go),
    .i_num   (r_num),
    .i_den   (r_den),
    .o_done  (w_div_done),
    .o_quo   (w_quo)
  );

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign wtime = r_wtime;

endmodule

// File: tb/tb_wtime_calc.sv
// Bench for wtime_calc: cycle-by-cycle comparison against a latency/arithmetic
// reference model, directed corner cases, random traffic and a WW=4 instance.
module tb_wtime_calc;

  localparam int PW  = 3;
  localparam int TW  = 2;
  localparam int SVC = 3;
  localparam int WW  = 5;
  localparam int NW_TB = $clog2(SVC * ((2**PW - 1) + (2**TW - 1) - 1) + 1);
  localparam int LAT = NW_TB + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start;
  logic [PW-1:0] pcount;
  logic [TW-1:0] tcount;
  logic          busy, done;
  logic [WW-1:0] wtime;

  logic          s_start;
  logic [PW-1:0] s_p;
  logic [TW-1:0] s_t;
  logic          s_busy, s_done;
  logic [3:0]    s_wtime;

  wtime_calc #(.PW(PW), .TW(TW), .SVC(SVC), .WW(WW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pcount (pcount),
    .tcount (tcount),
    .busy   (busy),
    .done   (done),
    .wtime  (wtime)
  );

  wtime_calc #(.PW(PW), .TW(TW), .SVC(SVC), .WW(4)) dut_sat (
    .clk    (clk),
    .rst    (rst),
    .start  (s_start),
    .pcount (s_p),
    .tcount (s_t),
    .busy   (s_busy),
    .done   (s_done),
    .wtime  (s_wtime)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int m_phase = 0;
  int m_pend  = 0;
  int m_wtime = 0;

  function automatic int ref_w(input int p, input int t, input int ww);
    int q, lim;
    if (p == 0 || t == 0) return 0;
    q   = (SVC * (p + t - 1)) / t;
    lim = (1 << ww) - 1;
    return (q > lim) ? lim : q;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a request accepted while idle finishes LAT cycles later.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_phase = 0;
      m_wtime = 0;
    end else if (m_phase == 0) begin
      if (start === 1'b1) begin
        m_phase = 1;
        m_pend  = ref_w(int'(pcount), int'(tcount), WW);
      end
    end else if (m_phase == LAT) begin
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == LAT) m_wtime = m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("done", 32'(done), 32'(m_phase == LAT));
      check("wtime", 32'(wtime), 32'(m_wtime));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input int p, input int t);
    start  = 1'b1;
    pcount = PW'(p);
    tcount = TW'(t);
    @(negedge clk);
    start  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pcount = '0; tcount = '0;
    s_start = 1'b0; s_p = '0; s_t = '0;
    cyc(3);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wtime", 32'(wtime), 32'd0);
    cyc(1);
    rst = 1'b0;

    check("ref_t1", 32'(ref_w(5, 1, WW)), 32'd15);
    check("ref_t2p2", 32'(ref_w(2, 2, WW)), 32'd4);
    check("ref_t3p7", 32'(ref_w(7, 3, WW)), 32'd9);
    check("ref_sat", 32'(ref_w(7, 1, 4)), 32'd15);
    check("ref_zero", 32'(ref_w(0, 3, WW)), 32'd0);

    go(5, 2);
    cyc(LAT - 1);
    check("p5t2_done", 32'(done), 32'd1);
    check("p5t2_busy", 32'(busy), 32'd1);
    check("p5t2_wtime", 32'(wtime), 32'd9);
    cyc(3);
    check("p5t2_hold", 32'(wtime), 32'd9);
    check("p5t2_idle", 32'(busy), 32'd0);

    go(7, 0);
    cyc(LAT - 1);
    check("t0_wtime", 32'(wtime), 32'd0);
    check("t0_done", 32'(done), 32'd1);
    cyc(1);
    go(0, 3);
    cyc(LAT - 1);
    check("p0_wtime", 32'(wtime), 32'd0);
    check("p0_done", 32'(done), 32'd1);
    cyc(1);

    for (int t = 0; t < 4; t++) begin
      for (int p = 0; p < 8; p++) begin
        go(p, t);
        cyc(LAT);
      end
    end

    start = 1'b1;
    for (int i = 0; i < 48; i++) begin
      pcount = PW'($urandom);
      tcount = TW'($urandom_range(1, 3));
      cyc(1);
    end
    start = 1'b0;
    cyc(LAT + 1);

    go(5, 2);
    cyc(LAT);
    go(6, 3);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wtime", 32'(wtime), 32'd0);
    rst = 1'b0;
    cyc(12);

    for (int i = 0; i < 400; i++) begin
      start  = ($urandom_range(0, 2) == 0);
      pcount = PW'($urandom);
      tcount = TW'($urandom);
      cyc(1);
    end
    start = 1'b0;
    cyc(LAT + 1);

    s_start = 1'b1; s_p = 3'd7; s_t = 2'd1;
    @(negedge clk);
    s_start = 1'b0;
    cyc(LAT - 1);
    check("sat_done", 32'(s_done), 32'd1);
    check("sat_busy", 32'(s_busy), 32'd1);
    check("sat_wtime", 32'(s_wtime), 32'd15);
    cyc(2);
    check("sat_hold", 32'(s_wtime), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
